// File: rtl/pifo_pop_monitor.sv
// Per-tree occupancy and pop-order checker for a vPIFO, with a ready/valid log FIFO
// holding every popped entry tagged with its error bit.
module pifo_pop_monitor #(
  parameter  int PTW       = 28,
  parameter  int MTW       = 20,
  parameter  int TREE_NUM  = 3,
  parameter  int CNT_W     = 17,
  parameter  int LOG_DEPTH = 16,
  localparam int TNB       = $clog2(TREE_NUM),
  localparam int LW        = 1 + TNB + MTW + PTW
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      i_clr,
  input  logic                      i_push,
  input  logic [TNB-1:0]            i_push_tree_id,
  input  logic [PTW-1:0]            i_push_priority,
  input  logic                      i_pop_out,
  input  logic [TNB-1:0]            i_pop_tree_id,
  input  logic [MTW+PTW-1:0]        i_pop_data,
  output logic [TREE_NUM*CNT_W-1:0] o_occupancy,
  output logic [CNT_W-1:0]          o_pop_cnt,
  output logic                      o_err_order,
  output logic                      o_err_underflow,
  output logic                      o_err_tree_id,
  output logic [CNT_W-1:0]          o_first_err_cnt,
  output logic                      o_log_valid,
  output logic [LW-1:0]             o_log_data,
  input  logic                      i_log_ready,
  output logic                      o_log_overflow,
  output logic [CNT_W-1:0]          o_drop_cnt
);
  localparam int AW = $clog2(LOG_DEPTH);

  logic [1:0] rst_sync;
  logic       rst_n;

  // Async assert, sync deassert.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [CNT_W-1:0]    occ       [TREE_NUM];
  logic [PTW-1:0]      last_pop  [TREE_NUM];
  logic [PTW-1:0]      min_since [TREE_NUM];
  logic [TREE_NUM-1:0] push_hit, pop_hit;
  logic                push_bad, pop_bad, underflow, order_err, err;
  logic [PTW-1:0]      pop_prio;

  assign pop_prio = i_pop_data[PTW-1:0];
  assign push_bad = i_push    && !({1'b0, i_push_tree_id} < (TNB+1)'(TREE_NUM));
  assign pop_bad  = i_pop_out && !({1'b0, i_pop_tree_id}  < (TNB+1)'(TREE_NUM));

  // Checks use pre-cycle state only; a same-cycle push is not visible to the pop.
  always_comb begin
    push_hit  = '0;
    pop_hit   = '0;
    underflow = 1'b0;
    order_err = 1'b0;
    for (int t = 0; t < TREE_NUM; t++) begin
      push_hit[t] = i_push    && (i_push_tree_id == TNB'(t));
      pop_hit[t]  = i_pop_out && (i_pop_tree_id  == TNB'(t));
      if (pop_hit[t]) begin
        underflow = (occ[t] == '0);
        order_err = (pop_prio < last_pop[t]) && (pop_prio < min_since[t]);
      end
    end
    err = underflow | order_err | pop_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        occ[t]       <= '0;
        last_pop[t]  <= '0;
        min_since[t] <= '1;
      end
    end else if (i_clr) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        occ[t]       <= '0;
        last_pop[t]  <= '0;
        min_since[t] <= '1;
      end
    end else begin
      for (int t = 0; t < TREE_NUM; t++) begin
        case ({push_hit[t], pop_hit[t]})
          2'b10:   if (occ[t] != '1) occ[t] <= occ[t] + CNT_W'(1);
          2'b01:   if (occ[t] != '0) occ[t] <= occ[t] - CNT_W'(1);
          2'b11:   if (occ[t] == '0) occ[t] <= CNT_W'(1);
          default: ;
        endcase
        if (pop_hit[t]) begin
          last_pop[t]  <= pop_prio;
          min_since[t] <= push_hit[t] ? i_push_priority : '1;
        end else if (push_hit[t] && (i_push_priority < min_since[t])) begin
          min_since[t] <= i_push_priority;
        end
      end
    end
  end

  always_comb begin
    o_occupancy = '0;
    for (int t = 0; t < TREE_NUM; t++) o_occupancy[t*CNT_W +: CNT_W] = occ[t];
  end

  logic [AW:0]     wr_ptr, rd_ptr, fifo_cnt;
  logic [LW-1:0]   mem [LOG_DEPTH];
  logic            fifo_full, fifo_empty, rd_en, wr_en, drop;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == (AW+1)'(LOG_DEPTH));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign rd_en      = !fifo_empty && i_log_ready;
  assign wr_en      = i_pop_out && (!fifo_full || rd_en);
  assign drop       = i_pop_out && fifo_full && !rd_en;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {err, i_pop_tree_id, i_pop_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign o_log_valid = !fifo_empty;
  assign o_log_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_clr) begin
      o_pop_cnt       <= '0;
      o_err_order     <= 1'b0;
      o_err_underflow <= 1'b0;
      o_err_tree_id   <= 1'b0;
      o_first_err_cnt <= '0;
      o_log_overflow  <= 1'b0;
      o_drop_cnt      <= '0;
    end else begin
      if (i_pop_out)            o_pop_cnt       <= o_pop_cnt + CNT_W'(1);
      if (order_err)            o_err_order     <= 1'b1;
      if (underflow)            o_err_underflow <= 1'b1;
      if (push_bad || pop_bad)  o_err_tree_id   <= 1'b1;
      if ((order_err || underflow) && !(o_err_order || o_err_underflow))
        o_first_err_cnt <= o_pop_cnt;
      if (drop) begin
        o_log_overflow <= 1'b1;
        o_drop_cnt     <= o_drop_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pifo_pop_monitor.sv
// Bench for pifo_pop_monitor: directed scenarios then random traffic, against a
// queue-based reference model with a decoupled log scoreboard.
module tb_pifo_pop_monitor;
  logic        clk, arst_n, clr, push, pop, log_ready;
  logic [1:0]  push_tid, pop_tid;
  logic [27:0] push_prio;
  logic [47:0] pop_data;
  logic [50:0] occupancy;
  logic [16:0] pop_cnt, first_err, drop_cnt;
  logic        e_order, e_under, e_tid, log_valid, log_ovf;
  logic [50:0] log_data;

  pifo_pop_monitor dut (
    .clk(clk), .arst_n(arst_n), .i_clr(clr),
    .i_push(push), .i_push_tree_id(push_tid), .i_push_priority(push_prio),
    .i_pop_out(pop), .i_pop_tree_id(pop_tid), .i_pop_data(pop_data),
    .o_occupancy(occupancy), .o_pop_cnt(pop_cnt),
    .o_err_order(e_order), .o_err_underflow(e_under), .o_err_tree_id(e_tid),
    .o_first_err_cnt(first_err), .o_log_valid(log_valid), .o_log_data(log_data),
    .i_log_ready(log_ready), .o_log_overflow(log_ovf), .o_drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned m_occ [3];
  logic [27:0] m_last [3];
  logic [27:0] m_min  [3];
  logic [16:0] m_pcnt, m_first, m_drop;
  bit          m_eo, m_eu, m_et, m_ov;
  int          m_fcnt;
  logic [50:0] sb_q [$];
  int          errors = 0, checks = 0;
  bit          mon_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Log scoreboard: compares whatever the DUT presents against queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("log_valid", {63'd0, log_valid}, {63'd0, (m_fcnt > 0)});
      if (log_valid && log_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL log_extra: got 0x%0h expected no entry", log_data);
        end else begin
          chk("log_data", {13'd0, log_data}, {13'd0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic model_clear_state();
    for (int t = 0; t < 3; t++) begin
      m_occ[t] = 0; m_last[t] = '0; m_min[t] = '1;
    end
    m_pcnt = '0; m_first = '0; m_drop = '0;
    m_eo = 0; m_eu = 0; m_et = 0; m_ov = 0;
  endtask

  task automatic check_regs();
    for (int t = 0; t < 3; t++)
      chk($sformatf("occupancy%0d", t), {47'd0, occupancy[t*17 +: 17]}, 64'(m_occ[t]));
    chk("pop_cnt",   {47'd0, pop_cnt},   {47'd0, m_pcnt});
    chk("first_err", {47'd0, first_err}, {47'd0, m_first});
    chk("drop_cnt",  {47'd0, drop_cnt},  {47'd0, m_drop});
    chk("flags", {60'd0, e_order, e_under, e_tid, log_ovf}, {60'd0, m_eo, m_eu, m_et, m_ov});
  endtask

  // One clock with the currently driven inputs; model advances alongside.
  task automatic step();
    logic [27:0] p;
    bit und, ord, err, rd, wr;
    logic [50:0] entry;
    und = 0; ord = 0; err = 0;
    p = pop_data[27:0];
    if (pop) begin
      if (pop_tid < 3) begin
        und = (m_occ[pop_tid] == 0);
        ord = (p < m_last[pop_tid]) && (p < m_min[pop_tid]);
      end
      err = (pop_tid >= 3) || und || ord;
    end
    entry = {err, pop_tid, pop_data};
    rd = (m_fcnt > 0) && log_ready;
    wr = pop && ((m_fcnt < 16) || rd);
    @(posedge clk); #1;
    if (wr) sb_q.push_back(entry);
    m_fcnt = m_fcnt + int'(wr) - int'(rd);
    if (clr) begin
      model_clear_state();
    end else begin
      if ((ord || und) && !(m_eo || m_eu)) m_first = m_pcnt;
      if (ord) m_eo = 1;
      if (und) m_eu = 1;
      if ((push && push_tid >= 3) || (pop && pop_tid >= 3)) m_et = 1;
      if (pop) m_pcnt++;
      if (pop && !wr) begin m_ov = 1; m_drop++; end
      if (pop && pop_tid < 3) begin
        if (m_occ[pop_tid] != 0) m_occ[pop_tid]--;
        m_last[pop_tid] = p;
        m_min[pop_tid]  = '1;
      end
      if (push && push_tid < 3) begin
        if (m_occ[push_tid] != 32'h1FFFF) m_occ[push_tid]++;
        if (push_prio < m_min[push_tid]) m_min[push_tid] = push_prio;
      end
    end
    check_regs();
  endtask

  task automatic do_reset();
    mon_en = 0;
    arst_n = 0; clr = 0; push = 0; pop = 0;
    #1;
    chk("rst_outputs", {10'd0, occupancy, pop_cnt[12:0]}, 64'd0);
    chk("rst_misc", {5'd0, first_err, drop_cnt, e_order, e_under, e_tid, log_valid, log_ovf, 20'd0},
        64'd0);
    chk("rst_log_data", {13'd0, log_data}, 64'd0);
    model_clear_state();
    sb_q.delete();
    m_fcnt = 0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1;
    repeat (3) @(posedge clk);
    #1 mon_en = 1;
  endtask

  task automatic do_push(input logic [1:0] t, input logic [27:0] pr);
    push = 1; push_tid = t; push_prio = pr;
    step();
    push = 0;
  endtask

  task automatic do_pop(input logic [1:0] t, input logic [27:0] pr);
    pop = 1; pop_tid = t; pop_data = {20'($urandom), pr};
    step();
    pop = 0;
  endtask

  task automatic do_clr();
    clr = 1; step(); clr = 0;
  endtask

  task automatic idle(input int n);
    push = 0; pop = 0; clr = 0;
    repeat (n) step();
  endtask

  initial begin
    push_tid = 0; pop_tid = 0; push_prio = 0; pop_data = 0; log_ready = 1;
    do_reset();

    do_push(0, 10); do_push(0, 5); do_push(0, 20);
    chk("t1_occ_after_push", {47'd0, occupancy[16:0]}, 64'd3);
    do_pop(0, 5); do_pop(0, 10); do_pop(0, 20);
    chk("t1_occ_after_pop", {47'd0, occupancy[16:0]}, 64'd0);
    chk("t1_pop_cnt", {47'd0, pop_cnt}, 64'd3);
    chk("t1_flags", {61'd0, e_order, e_under, e_tid}, 64'd0);
    idle(3);

    do_clr();
    do_push(1, 10); do_pop(1, 10); do_push(1, 5); do_pop(1, 5);
    chk("t2_no_order_err", {63'd0, e_order}, 64'd0);
    do_push(1, 7); do_pop(1, 3);
    chk("t2_order_err", {63'd0, e_order}, 64'd1);
    chk("t2_first_err", {47'd0, first_err}, 64'd2);
    idle(3);

    do_clr();
    do_pop(2, 4);
    chk("t3_underflow", {63'd0, e_under}, 64'd1);
    chk("t3_occ_zero", {47'd0, occupancy[50:34]}, 64'd0);
    push = 1; push_tid = 2; push_prio = 9;
    do_pop(2, 9);
    push = 0;
    chk("t3_same_cycle_occ", {47'd0, occupancy[50:34]}, 64'd1);
    idle(3);

    do_clr();
    log_ready = 0;
    for (int i = 0; i < 18; i++) do_pop(0, 28'($urandom_range(0, 100)));
    chk("t4_drop_cnt", {47'd0, drop_cnt}, 64'd2);
    chk("t4_overflow", {63'd0, log_ovf}, 64'd1);
    log_ready = 1;
    idle(16);
    chk("t4_drained", {63'd0, log_valid}, 64'd0);

    do_clr();
    do_push(3, 1); do_pop(3, 1);
    chk("t5_tree_id", {63'd0, e_tid}, 64'd1);
    chk("t5_occ", {13'd0, occupancy}, 64'd0);
    chk("t5_pop_cnt", {47'd0, pop_cnt}, 64'd1);
    idle(3);

    log_ready = 0;
    for (int i = 0; i < 5; i++) do_pop(1, 28'(i));
    do_clr();
    chk("t6_clr_pop_cnt", {47'd0, pop_cnt}, 64'd0);
    chk("t6_fifo_kept", {63'd0, log_valid}, 64'd1);
    log_ready = 1;
    idle(2);
    do_reset();
    chk("t6_rst_valid", {63'd0, log_valid}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      push      = 1'($urandom_range(0, 1));
      push_tid  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      push_prio = 28'($urandom_range(0, 63));
      pop       = ($urandom_range(0, 2) != 0);
      pop_tid   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      pop_data  = {20'($urandom), 28'($urandom_range(0, 63))};
      log_ready = ((i / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 199) == 0);
      step();
    end
    log_ready = 1;
    idle(20);
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
